// File: rtl/ola_capture_buffer.sv
// Capture buffer behind the trigger engine: circular pre-trigger history, programmable
// post-trigger tail, then oldest-first readout over a valid/ready port.
module ola_capture_buffer #(
  parameter int sample_width = 8,
  parameter int depth_width  = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    ctl_arm,
  input  logic                    ctl_abort,
  input  logic [depth_width-1:0]  ctl_post_count,
  input  logic                    in_valid,
  input  logic [sample_width-1:0] in_sample,
  input  logic                    in_trigger,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [sample_width-1:0] rd_data,
  output logic                    st_armed,
  output logic                    st_triggered,
  output logic                    st_done
);

  localparam int unsigned Depth = 2 ** depth_width;
  localparam logic [depth_width:0] FillMax = {1'b1, {depth_width{1'b0}}};

  typedef enum logic [1:0] {IDLE, ARMED, POST, READOUT} state_e;

  state_e                  state_q, state_d;
  logic [depth_width-1:0]  wr_ptr_q, wr_ptr_d;
  logic [depth_width:0]    fill_q, fill_d;
  logic [depth_width-1:0]  post_len_q, post_len_d;
  logic [depth_width-1:0]  post_cnt_q, post_cnt_d;
  logic [depth_width-1:0]  rd_ptr_q, rd_ptr_d;
  logic [depth_width:0]    rd_cnt_q, rd_cnt_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [sample_width-1:0] rd_data_q, rd_data_d;
  logic                    armed_q, armed_d;
  logic                    triggered_q, triggered_d;
  logic                    done_q, done_d;

  logic                    wr_en;
  logic                    enter_readout;
  logic [depth_width-1:0]  wr_ptr_inc;
  logic [depth_width:0]    fill_inc;

  logic [sample_width-1:0] mem [Depth];

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    post_len_d    = post_len_q;
    post_cnt_d    = post_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    rd_cnt_d      = rd_cnt_q;
    rd_valid_d    = rd_valid_q;
    rd_data_d     = rd_data_q;
    triggered_d   = triggered_q;
    done_d        = 1'b0;
    wr_en         = 1'b0;
    enter_readout = 1'b0;
    wr_ptr_inc    = wr_ptr_q + 1'b1;
    fill_inc      = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (ctl_arm) begin
          state_d     = ARMED;
          post_len_d  = ctl_post_count;
          fill_d      = '0;
          wr_ptr_d    = '0;
          triggered_d = 1'b0;
        end
      end
      ARMED: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_inc;
          fill_d   = fill_inc;
          if (in_trigger) begin
            triggered_d = 1'b1;
            if (post_len_q == '0) begin
              enter_readout = 1'b1;
            end else begin
              post_cnt_d = post_len_q;
              state_d    = POST;
            end
          end
        end
      end
      POST: begin
        if (in_valid) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_inc;
          fill_d     = fill_inc;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == depth_width'(1)) enter_readout = 1'b1;
        end
      end
      READOUT: begin
        if ((!rd_valid_q || rd_ready) && (rd_cnt_q != '0)) begin
          rd_data_d  = mem[rd_ptr_q];
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          rd_cnt_d   = rd_cnt_q - 1'b1;
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Oldest entry is computed from the post-write pointer/fill; a full buffer
    // (fill = depth) wraps back to wr_ptr itself.
    if (enter_readout) begin
      state_d  = READOUT;
      rd_ptr_d = wr_ptr_d - fill_d[depth_width-1:0];
      rd_cnt_d = fill_d;
    end

    if (ctl_abort) begin
      state_d     = IDLE;
      rd_valid_d  = 1'b0;
      triggered_d = 1'b0;
      done_d      = 1'b0;
      wr_en       = 1'b0;
    end

    armed_d = (state_d == ARMED) || (state_d == POST);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_len_q  <= '0;
      post_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      post_len_q  <= post_len_d;
      post_cnt_q  <= post_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= in_sample;
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign st_armed     = armed_q;
  assign st_triggered = triggered_q;
  assign st_done      = done_q;

endmodule
